// File: rtl/rd_resp_router_if.sv
`default_nettype none
// ============================================================================
// Module      : rd_resp_router_if
// Description : Read-channel bundle between one AXI master port and NUM_SL
//               slave read ports, as seen by rd_resp_router.
// Revision    : 1.0  initial release
// ============================================================================
interface rd_resp_router_if #(
    parameter int NUM_SL = 2,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
);
    logic                     rd_ARVALID;
    logic [ID_W-1:0]          rd_ARID;
    logic [NUM_SL-1:0]        ar_sel;
    logic                     rd_ARREADY;
    logic [NUM_SL-1:0]        s_ARVALID;
    logic [NUM_SL-1:0]        s_ARREADY;
    logic [NUM_SL-1:0]        s_RVALID;
    logic [NUM_SL-1:0]        s_RLAST;
    logic [NUM_SL*ID_W-1:0]   s_RID;
    logic [NUM_SL*DATA_W-1:0] s_RDATA;
    logic [NUM_SL*2-1:0]      s_RRESP;
    logic [NUM_SL-1:0]        s_RREADY;
    logic                     rd_RVALID;
    logic                     rd_RLAST;
    logic [ID_W-1:0]          rd_RID;
    logic [DATA_W-1:0]        rd_RDATA;
    logic [1:0]               rd_RRESP;
    logic                     rd_RREADY;

    // Router-side view.
    modport slave (
        input  rd_ARVALID, rd_ARID, ar_sel, s_ARREADY,
        input  s_RVALID, s_RLAST, s_RID, s_RDATA, s_RRESP, rd_RREADY,
        output rd_ARREADY, s_ARVALID, s_RREADY,
        output rd_RVALID, rd_RLAST, rd_RID, rd_RDATA, rd_RRESP
    );

    // Environment-side view (upstream master plus downstream slaves).
    modport master (
        output rd_ARVALID, rd_ARID, ar_sel, s_ARREADY,
        output s_RVALID, s_RLAST, s_RID, s_RDATA, s_RRESP, rd_RREADY,
        input  rd_ARREADY, s_ARVALID, s_RREADY,
        input  rd_RVALID, rd_RLAST, rd_RID, rd_RDATA, rd_RRESP
    );
endinterface
`default_nettype wire

// File: rtl/rd_resp_router.sv
`default_nettype none
// ============================================================================
// Module      : rd_resp_router
// Description : In-order AXI read router, one master to NUM_SL slaves, with an
//               outstanding-read tracking FIFO, a 2-entry R skid buffer and
//               local single-beat DECERR for unmapped addresses.
// Revision    : 1.0  initial release
// ============================================================================
module rd_resp_router #(
    parameter int NUM_SL = 2,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    rd_resp_router_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding
);
    localparam int c_IDX_W  = $clog2(NUM_SL);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH+1);
    localparam int c_BEAT_W = ID_W + DATA_W + 3;

    logic                r_fifo_err [DEPTH];
    logic [c_IDX_W-1:0]  r_fifo_idx [DEPTH];
    logic [ID_W-1:0]     r_fifo_id  [DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;

    logic                r_out_valid;
    logic [c_BEAT_W-1:0] r_out_beat;
    logic                r_skid_valid;
    logic [c_BEAT_W-1:0] r_skid_beat;

    logic [c_IDX_W-1:0]  w_sel;
    logic                w_onehot;
    logic                w_full;
    logic                w_empty;
    logic                w_buf_full;
    logic                w_push;
    logic                w_pop;
    logic                w_bypass;
    logic                w_h_err;
    logic [c_IDX_W-1:0]  w_h_idx;
    logic [ID_W-1:0]     w_h_id;
    logic                w_r_open;
    logic                w_s_valid;
    logic                w_s_last;
    logic [c_BEAT_W-1:0] w_s_beat;
    logic                w_accept;
    logic                w_inject;
    logic                w_in_valid;
    logic [c_BEAT_W-1:0] w_in_beat;
    logic                w_drain;
    logic [NUM_SL-1:0]   w_rready;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_SL; i++) begin
            if (bus.ar_sel[i]) w_sel = c_IDX_W'(i);
        end
    end

    assign w_onehot   = $onehot(bus.ar_sel);
    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_buf_full = r_out_valid & r_skid_valid;

    assign bus.rd_ARREADY = ~ARESET & ~w_full & (w_onehot ? bus.s_ARREADY[w_sel] : 1'b1);
    assign bus.s_ARVALID  = {NUM_SL{~ARESET & bus.rd_ARVALID & w_onehot & ~w_full}} & bus.ar_sel;
    assign w_push         = bus.rd_ARVALID & bus.rd_ARREADY;

    // An unmapped read arriving at an empty FIFO answers on the push edge itself.
    assign w_bypass = w_push & ~w_onehot & w_empty & ~w_buf_full;

    assign w_h_err  = r_fifo_err[r_rptr];
    assign w_h_idx  = r_fifo_idx[r_rptr];
    assign w_h_id   = r_fifo_id[r_rptr];
    assign w_r_open = ~ARESET & ~w_empty & ~w_buf_full;

    always_comb begin
        w_s_valid = 1'b0;
        w_s_last  = 1'b0;
        w_s_beat  = '0;
        w_rready  = '0;
        for (int i = 0; i < NUM_SL; i++) begin
            if (c_IDX_W'(i) == w_h_idx) begin
                w_s_valid   = bus.s_RVALID[i];
                w_s_last    = bus.s_RLAST[i];
                w_s_beat    = {bus.s_RID[i*ID_W +: ID_W], bus.s_RDATA[i*DATA_W +: DATA_W],
                               bus.s_RRESP[i*2 +: 2], bus.s_RLAST[i]};
                w_rready[i] = w_r_open & ~w_h_err;
            end
        end
    end

    assign bus.s_RREADY = w_rready;
    assign w_accept     = w_r_open & ~w_h_err & w_s_valid;
    assign w_inject     = w_r_open & w_h_err;
    assign w_pop        = (w_accept & w_s_last) | w_inject | w_bypass;
    assign w_drain      = r_out_valid & bus.rd_RREADY;

    always_comb begin
        w_in_valid = 1'b0;
        w_in_beat  = '0;
        if (w_bypass) begin
            w_in_valid = 1'b1;
            w_in_beat  = {bus.rd_ARID, {DATA_W{1'b0}}, 2'b11, 1'b1};
        end else if (w_inject) begin
            w_in_valid = 1'b1;
            w_in_beat  = {w_h_id, {DATA_W{1'b0}}, 2'b11, 1'b1};
        end else if (w_accept) begin
            w_in_valid = 1'b1;
            w_in_beat  = w_s_beat;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_fifo_err[r_wptr] <= ~w_onehot;
            r_fifo_idx[r_wptr] <= w_sel;
            r_fifo_id[r_wptr]  <= bus.rd_ARID;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + c_CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - c_CNT_W'(1);
        end
    end

    // Skid buffer: r_out_* is the head presented to the master, r_skid_* the second slot.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_out_valid  <= 1'b0;
            r_out_beat   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_beat  <= '0;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                r_out_beat   <= r_skid_beat;
                r_skid_valid <= w_in_valid;
                if (w_in_valid) r_skid_beat <= w_in_beat;
            end else begin
                r_out_valid <= w_in_valid;
                if (w_in_valid) r_out_beat <= w_in_beat;
            end
        end else if (w_in_valid) begin
            if (r_out_valid) begin
                r_skid_valid <= 1'b1;
                r_skid_beat  <= w_in_beat;
            end else begin
                r_out_valid <= 1'b1;
                r_out_beat  <= w_in_beat;
            end
        end
    end

    assign bus.rd_RVALID = r_out_valid;
    assign bus.rd_RID    = r_out_beat[c_BEAT_W-1 -: ID_W];
    assign bus.rd_RDATA  = r_out_beat[DATA_W+2 -: DATA_W];
    assign bus.rd_RRESP  = r_out_beat[2:1];
    assign bus.rd_RLAST  = r_out_beat[0];
    assign outstanding   = r_count;
endmodule
`default_nettype wire

// File: tb/tb_rd_resp_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_resp_router
// Description : Randomised self-checking bench for rd_resp_router against a
//               transaction-level queue model of the routing rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rd_resp_router;
    localparam int NUM_SL = 2;
    localparam int DATA_W = 32;
    localparam int ID_W   = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic             ACLK = 1'b0;
    logic             ARESET = 1'b1;
    logic [CNT_W-1:0] outstanding;

    rd_resp_router_if #(.NUM_SL(NUM_SL), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    rd_resp_router #(.NUM_SL(NUM_SL), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .bus         (bus),
        .outstanding (outstanding)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    typedef struct {
        bit              err;
        int              idx;
        logic [ID_W-1:0] id;
    } tx_t;

    beat_t slv_q [NUM_SL][$];
    tx_t   tx_q[$];
    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_inputs(input int pa, input int pv, input int pr);
        int r;
        logic [NUM_SL-1:0] vld, lst, ardy;
        vld = '0; lst = '0; ardy = '0;
        bus.rd_ARVALID = ($urandom_range(99) < pa);
        bus.rd_ARID    = ID_W'($urandom);
        r = $urandom_range(99);
        if (r < 35)      bus.ar_sel = 2'b01;
        else if (r < 70) bus.ar_sel = 2'b10;
        else if (r < 85) bus.ar_sel = 2'b00;
        else             bus.ar_sel = 2'b11;
        for (int i = 0; i < NUM_SL; i++) begin
            ardy[i] = ($urandom_range(99) < 75);
            if (slv_q[i].size() != 0 && $urandom_range(99) < pv) begin
                vld[i] = 1'b1;
                lst[i] = slv_q[i][0].last;
                bus.s_RID[i*ID_W +: ID_W]       = slv_q[i][0].id;
                bus.s_RDATA[i*DATA_W +: DATA_W] = slv_q[i][0].data;
                bus.s_RRESP[i*2 +: 2]           = slv_q[i][0].resp;
            end else begin
                lst[i] = 1'($urandom);
                bus.s_RID[i*ID_W +: ID_W]       = ID_W'($urandom);
                bus.s_RDATA[i*DATA_W +: DATA_W] = $urandom;
                bus.s_RRESP[i*2 +: 2]           = 2'($urandom);
            end
        end
        bus.s_RVALID  = vld;
        bus.s_RLAST   = lst;
        bus.s_ARREADY = ardy;
        bus.rd_RREADY = ($urandom_range(99) < pr);
    endtask

    // Compare DUT against the model, then advance the model across the coming edge.
    task automatic step();
        int cnt, sel, len;
        bit onehot, full, exp_ardy, drain, room, have;
        logic [NUM_SL-1:0] exp_arv, exp_rr;
        beat_t nb, sb;
        tx_t t;
        cnt    = tx_q.size();
        onehot = ($countones(bus.ar_sel) == 1);
        sel    = 0;
        for (int i = 0; i < NUM_SL; i++) if (bus.ar_sel[i]) sel = i;
        full     = (cnt == DEPTH);
        exp_ardy = !full && (onehot ? bus.s_ARREADY[sel] : 1'b1);
        exp_arv  = (bus.rd_ARVALID && onehot && !full) ? bus.ar_sel : '0;
        exp_rr   = '0;
        if (cnt > 0 && !tx_q[0].err && exp_q.size() < 2) exp_rr[tx_q[0].idx] = 1'b1;

        chk("ar_ready", 64'(bus.rd_ARREADY), 64'(exp_ardy));
        chk("s_arvalid", 64'(bus.s_ARVALID), 64'(exp_arv));
        chk("s_rready", 64'(bus.s_RREADY), 64'(exp_rr));
        chk("outstanding", 64'(outstanding), 64'(cnt));
        chk("rd_rvalid", 64'(bus.rd_RVALID), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            chk("rd_beat", 64'({bus.rd_RID, bus.rd_RDATA, bus.rd_RRESP, bus.rd_RLAST}), 64'(exp_q[0]));

        drain = (exp_q.size() != 0) && bus.rd_RREADY;
        room  = (exp_q.size() < 2);
        have  = 1'b0;
        nb    = '0;
        if (cnt > 0 && room) begin
            if (tx_q[0].err) begin
                nb   = '{id: tx_q[0].id, data: '0, resp: 2'b11, last: 1'b1};
                have = 1'b1;
                void'(tx_q.pop_front());
            end else if (bus.s_RVALID[tx_q[0].idx]) begin
                nb   = slv_q[tx_q[0].idx].pop_front();
                have = 1'b1;
                if (nb.last) void'(tx_q.pop_front());
            end
        end
        if (bus.rd_ARVALID && exp_ardy) begin
            if (!onehot && cnt == 0 && room) begin
                nb   = '{id: bus.rd_ARID, data: '0, resp: 2'b11, last: 1'b1};
                have = 1'b1;
            end else begin
                t.err = !onehot; t.idx = sel; t.id = bus.rd_ARID;
                tx_q.push_back(t);
                if (onehot) begin
                    len = $urandom_range(1, 8);
                    for (int b = 0; b < len; b++) begin
                        sb.id   = bus.rd_ARID;
                        sb.data = $urandom;
                        sb.resp = ($urandom_range(9) == 0) ? 2'b10 : 2'b00;
                        sb.last = (b == len - 1);
                        slv_q[sel].push_back(sb);
                    end
                end
            end
        end
        if (drain) void'(exp_q.pop_front());
        if (have) exp_q.push_back(nb);
    endtask

    task automatic run_phase(input int n, input int pa, input int pv, input int pr);
        for (int c = 0; c < n; c++) begin
            drive_inputs(pa, pv, pr);
            @(negedge ACLK);
            step();
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_rvalid"}, 64'(bus.rd_RVALID), 64'd0);
        chk({pfx, "_outstanding"}, 64'(outstanding), 64'd0);
        chk({pfx, "_arready"}, 64'(bus.rd_ARREADY), 64'd0);
        chk({pfx, "_s_arvalid"}, 64'(bus.s_ARVALID), 64'd0);
        chk({pfx, "_s_rready"}, 64'(bus.s_RREADY), 64'd0);
        chk({pfx, "_rbeat"}, 64'({bus.rd_RID, bus.rd_RDATA, bus.rd_RRESP, bus.rd_RLAST}), 64'd0);
    endtask

    task automatic force_busy_inputs();
        bus.rd_ARVALID = 1'b1;
        bus.rd_ARID    = 8'h5A;
        bus.ar_sel     = 2'b01;
        bus.s_ARREADY  = '1;
        bus.s_RVALID   = '1;
        bus.s_RLAST    = '0;
        bus.s_RID      = '1;
        bus.s_RDATA    = '1;
        bus.s_RRESP    = '0;
        bus.rd_RREADY  = 1'b1;
    endtask

    initial begin
        force_busy_inputs();
        #2;
        reset_checks("rst");
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        run_phase(300, 50, 70, 70);
        run_phase(150, 85, 3, 70);
        run_phase(200, 60, 90, 10);
        ARESET = 1'b1;
        force_busy_inputs();
        #1;
        reset_checks("midrst");
        tx_q.delete();
        exp_q.delete();
        for (int i = 0; i < NUM_SL; i++) slv_q[i].delete();
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        run_phase(300, 50, 100, 100);
        run_phase(200, 40, 80, 60);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
